// File: rtl/float_fixed_pkg.sv
// Shared types and constants for the float <-> fixed JRT call blocks.
package float_fixed_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_SHIFT,
    S_PACK,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    C_ZERO,
    C_NORM,
    C_INF,
    C_NAN
  } cls_t;

  localparam int          FLT_BIAS    = 127;
  localparam int          FLT_MANT_W  = 23;
  localparam int          FLT_EXP_MAX = 255;
  localparam logic [31:0] FIX_MAX     = 32'h7FFF_FFFF;
  localparam logic [31:0] FIX_MIN     = 32'h8000_0000;

  // Denormals are folded into ZERO: their magnitude is below any representable LSB.
  function automatic cls_t classify(input logic [7:0] exp, input logic [22:0] mant);
    if (exp == 8'd0)                      return C_ZERO;
    if (exp == 8'(FLT_EXP_MAX) && mant == '0) return C_INF;
    if (exp == 8'(FLT_EXP_MAX))           return C_NAN;
    return C_NORM;
  endfunction

endpackage

// File: rtl/floattofixed_jrt_if.sv
// run req/busy/return call interface with ce gating.
interface floattofixed_jrt_if;
  logic        ce;
  logic        i_run_req;
  logic [31:0] i_run_input_a_0;
  logic        o_run_busy;
  logic [31:0] o_run_return;

  modport master (output ce, i_run_req, i_run_input_a_0, input o_run_busy, o_run_return);
  modport slave  (input ce, i_run_req, i_run_input_a_0, output o_run_busy, o_run_return);
endinterface

// File: rtl/float_to_fixed_core.sv
// Registered DECODE/SHIFT datapath; fix is the PACK-stage result, valid while state==S_PACK.
module float_to_fixed_core
  import float_fixed_pkg::*;
#(
  parameter int FRAC_BITS = 0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        advance,
  input  state_t      state,
  input  logic [31:0] operand,
  output logic [31:0] fix
);

  localparam logic signed [9:0] SH_OFS = 10'(FRAC_BITS - FLT_BIAS - FLT_MANT_W);

  logic               sign_q;
  cls_t               cls_q;
  logic signed [9:0]  sh_q;
  logic [22:0]        mant_q;
  logic [55:0]        mag_q;
  logic               ovf_q;

  logic signed [9:0]  sh_d;
  logic [9:0]         nsh;
  logic [23:0]        sig;
  logic [55:0]        mag_d;
  logic               ovf_d;

  assign sh_d = $signed({2'b00, operand[30:23]}) + SH_OFS;
  assign sig  = {1'b1, mant_q};
  assign nsh  = 10'(-sh_q);

  always_comb begin
    mag_d = '0;
    ovf_d = 1'b0;
    if (!sh_q[9]) begin
      ovf_d = (sh_q > 10'sd31);
      mag_d = {32'b0, sig} << sh_q[4:0];
    end else if (nsh < 10'd24) begin
      mag_d = {32'b0, sig} >> nsh[4:0];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sign_q <= 1'b0;
      cls_q  <= C_ZERO;
      sh_q   <= '0;
      mant_q <= '0;
      mag_q  <= '0;
      ovf_q  <= 1'b0;
    end else if (advance) begin
      if (state == S_DECODE) begin
        sign_q <= operand[31];
        cls_q  <= classify(operand[30:23], operand[22:0]);
        sh_q   <= sh_d;
        mant_q <= operand[22:0];
      end
      if (state == S_SHIFT) begin
        mag_q <= mag_d;
        ovf_q <= ovf_d;
      end
    end
  end

  // -2^31 is exactly representable, so the negative bound is one larger.
  always_comb begin
    fix = '0;
    unique case (cls_q)
      C_ZERO, C_NAN: fix = '0;
      C_INF:         fix = sign_q ? FIX_MIN : FIX_MAX;
      C_NORM: begin
        if (!sign_q)
          fix = (ovf_q || mag_q > 56'h7FFF_FFFF) ? FIX_MAX : mag_q[31:0];
        else
          fix = (ovf_q || mag_q > 56'h8000_0000) ? FIX_MIN : 32'(-mag_q[31:0]);
      end
    endcase
  end

endmodule

// File: rtl/floattofixed_jrt.sv
// Float-to-fixed JRT call wrapper: handshake FSM, operand latch and return register.
module floattofixed_jrt
  import float_fixed_pkg::*;
#(
  parameter int FRAC_BITS = 0
) (
  input  logic              clock,
  input  logic              reset_n,
  floattofixed_jrt_if.slave run
);

  state_t      state;
  logic [31:0] operand;
  logic        busy;
  logic [31:0] ret;
  logic [31:0] fix;

  assign run.o_run_busy   = busy;
  assign run.o_run_return = ret;

  float_to_fixed_core #(.FRAC_BITS(FRAC_BITS)) u_core (
    .clock   (clock),
    .reset_n (reset_n),
    .advance (run.ce),
    .state   (state),
    .operand (operand),
    .fix     (fix)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      operand <= '0;
      busy    <= 1'b0;
      ret     <= '0;
    end else if (run.ce) begin
      unique case (state)
        S_IDLE: begin
          if (run.i_run_req) begin
            operand <= run.i_run_input_a_0;
            busy    <= 1'b1;
            state   <= S_DECODE;
          end else begin
            busy <= 1'b0;
          end
        end
        S_DECODE: state <= S_SHIFT;
        S_SHIFT:  state <= S_PACK;
        S_PACK: begin
          ret   <= fix;
          state <= S_DONE;
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
